time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 125 ++++++++++++
 tb/tb_time_set_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks hours/minutes/seconds with mode/inc/dec buttons, then strobes time_ow.
// Define TIME_SET_TIMEOUT_EN to abandon an edit after TIMEOUT_CYCLES cycles without a button press.
module time_set_ctrl #(
  parameter int OW_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] time_cur,
  output logic [16:0] time_set,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  edit_field
);

  typedef enum logic [2:0] {IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_e;

  if (OW_CYCLES < 1 || OW_CYCLES > 255 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777216) begin : gBadParams
    $error("time_set_ctrl: OW_CYCLES or TIMEOUT_CYCLES out of legal range");
  end

  state_e      state_q, state_d;
  logic [16:0] shadow_q, shadow_d;
  logic [7:0]  owCnt_q, owCnt_d;
  logic        modePrev_q, incPrev_q, decPrev_q;
  logic        modeEv, incEv, decEv;
  logic [4:0]  hrStep;
  logic [5:0]  minStep, secStep;

  // Out-of-range values behave as if already at the maximum: inc wraps to 0, dec lands on max.
  function automatic logic [4:0] stepHour(input logic [4:0] val, input logic up, input logic down);
    if (up && !down)      stepHour = (val >= 5'd23) ? 5'd0 : val + 5'd1;
    else if (down && !up) stepHour = (val == 5'd0 || val > 5'd23) ? 5'd23 : val - 5'd1;
    else                  stepHour = val;
  endfunction

  function automatic logic [5:0] stepSixty(input logic [5:0] val, input logic up, input logic down);
    if (up && !down)      stepSixty = (val >= 6'd59) ? 6'd0 : val + 6'd1;
    else if (down && !up) stepSixty = (val == 6'd0 || val > 6'd59) ? 6'd59 : val - 6'd1;
    else                  stepSixty = val;
  endfunction

  assign modeEv  = btn_mode & ~modePrev_q;
  assign incEv   = btn_inc  & ~incPrev_q;
  assign decEv   = btn_dec  & ~decPrev_q;
  assign hrStep  = stepHour(shadow_q[16:12], incEv, decEv);
  assign minStep = stepSixty(shadow_q[11:6], incEv, decEv);
  assign secStep = stepSixty(shadow_q[5:0], incEv, decEv);

`ifdef TIME_SET_TIMEOUT_EN
  logic [24:0] toCnt_q, toCnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    owCnt_d  = '0;
    unique case (state_q)
      IDLE: if (modeEv) begin
        shadow_d = time_cur;
        state_d  = EDIT_HR;
      end
      EDIT_HR:  if (modeEv) state_d = EDIT_MIN; else shadow_d[16:12] = hrStep;
      EDIT_MIN: if (modeEv) state_d = EDIT_SEC; else shadow_d[11:6]  = minStep;
      EDIT_SEC: if (modeEv) state_d = COMMIT;   else shadow_d[5:0]   = secStep;
      COMMIT: begin
        if (owCnt_q == 8'(OW_CYCLES - 1)) state_d = IDLE;
        else                              owCnt_d = owCnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
`ifdef TIME_SET_TIMEOUT_EN
    // Any press clears the idle count; mode is the only way to change state inside editing.
    toCnt_d = '0;
    if (editing && !(modeEv || incEv || decEv)) begin
      if (toCnt_q == 25'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      else                                    toCnt_d = toCnt_q + 25'd1;
    end
`endif
  end

  // Previous-value registers reset high so a button held through reset is ignored until re-pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      owCnt_q    <= '0;
      modePrev_q <= 1'b1;
      incPrev_q  <= 1'b1;
      decPrev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      owCnt_q    <= owCnt_d;
      modePrev_q <= btn_mode;
      incPrev_q  <= btn_inc;
      decPrev_q  <= btn_dec;
    end
  end

`ifdef TIME_SET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) toCnt_q <= '0;
    else     toCnt_q <= toCnt_d;
  end
`endif

  assign time_set = shadow_q;
  assign time_ow  = (state_q == COMMIT);
  assign editing  = (state_q == EDIT_HR) || (state_q == EDIT_MIN) || (state_q == EDIT_SEC);

  always_comb begin
    edit_field = 2'd0;
    unique case (state_q)
      EDIT_HR:  edit_field = 2'd1;
      EDIT_MIN: edit_field = 2'd2;
      EDIT_SEC: edit_field = 2'd3;
      default:  edit_field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edit walk, wraps, simultaneous buttons, held-through-reset,
// timeout (both builds of TIME_SET_TIMEOUT_EN) and reset during the overwrite strobe.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec;
  logic [16:0] time_cur;
  logic [16:0] time_set;
  logic        time_ow;
  logic        editing;
  logic [1:0]  edit_field;

  int nChecks = 0;
  int nFail   = 0;

  time_set_ctrl #(.OW_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .time_cur(time_cur), .time_set(time_set), .time_ow(time_ow),
    .editing(editing), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mkTime(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm, ss;
    hh = 5'(h); mm = 6'(m); ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    tick();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick();
  endtask

  task automatic leaveToIdle(input int modes);
    for (int k = 0; k < modes; k++) press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; time_cur = mkTime(1, 2, 3);
    tick(); tick();
    rst = 1'b0;
    tick();
    nChecks++; if (time_set !== 17'd0) begin nFail++; $display("[TB] FAIL reset_time_set: got %h expected %h", time_set, 17'd0); end
    nChecks++; if (time_ow !== 1'b0) begin nFail++; $display("[TB] FAIL reset_time_ow: got %b expected 0", time_ow); end
    nChecks++; if (editing !== 1'b0) begin nFail++; $display("[TB] FAIL reset_editing: got %b expected 0", editing); end
    nChecks++; if (edit_field !== 2'd0) begin nFail++; $display("[TB] FAIL reset_edit_field: got %0d expected 0", edit_field); end
  endtask

  task automatic test_commit();
    int highCnt;
    time_cur = mkTime(17, 30, 45);
    press(1'b1, 1'b0, 1'b0);
    nChecks++; if (edit_field !== 2'd1 || editing !== 1'b1) begin nFail++; $display("[TB] FAIL commit_field_hr: got %0d/%b expected 1/1", edit_field, editing); end
    nChecks++; if (time_set !== mkTime(17, 30, 45)) begin nFail++; $display("[TB] FAIL commit_load: got %h expected %h", time_set, mkTime(17, 30, 45)); end
    press(1'b1, 1'b0, 1'b0);
    nChecks++; if (edit_field !== 2'd2) begin nFail++; $display("[TB] FAIL commit_field_min: got %0d expected 2", edit_field); end
    press(1'b1, 1'b0, 1'b0);
    nChecks++; if (edit_field !== 2'd3) begin nFail++; $display("[TB] FAIL commit_field_sec: got %0d expected 3", edit_field); end
    time_cur = mkTime(1, 1, 1);
    btn_mode = 1'b1;
    highCnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      btn_mode = 1'b0;
      if (time_ow === 1'b1) highCnt++;
      if (k < 4) begin
        nChecks++; if (time_ow !== 1'b1 || editing !== 1'b0 || edit_field !== 2'd0) begin nFail++; $display("[TB] FAIL commit_ow_high_%0d: got ow=%b ed=%b f=%0d expected 1/0/0", k, time_ow, editing, edit_field); end
      end
      nChecks++; if (time_set !== mkTime(17, 30, 45)) begin nFail++; $display("[TB] FAIL commit_time_set_%0d: got %h expected %h", k, time_set, mkTime(17, 30, 45)); end
    end
    nChecks++; if (highCnt !== 4) begin nFail++; $display("[TB] FAIL commit_ow_len: got %0d expected 4", highCnt); end
    nChecks++; if (time_ow !== 1'b0 || editing !== 1'b0) begin nFail++; $display("[TB] FAIL commit_idle: got ow=%b ed=%b expected 0/0", time_ow, editing); end
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(17, 30, 45) || editing !== 1'b0) begin nFail++; $display("[TB] FAIL idle_inc_ignored: got %h/%b expected %h/0", time_set, editing, mkTime(17, 30, 45)); end
  endtask

  task automatic test_wrap();
    time_cur = mkTime(23, 59, 59);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(0, 59, 59)) begin nFail++; $display("[TB] FAIL wrap_hr_inc: got %h expected %h", time_set, mkTime(0, 59, 59)); end
    press(1'b0, 1'b0, 1'b1);
    nChecks++; if (time_set !== mkTime(23, 59, 59)) begin nFail++; $display("[TB] FAIL wrap_hr_dec: got %h expected %h", time_set, mkTime(23, 59, 59)); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(23, 0, 59)) begin nFail++; $display("[TB] FAIL wrap_min_inc: got %h expected %h", time_set, mkTime(23, 0, 59)); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(23, 0, 0)) begin nFail++; $display("[TB] FAIL wrap_sec_inc: got %h expected %h", time_set, mkTime(23, 0, 0)); end
    press(1'b0, 1'b0, 1'b1);
    nChecks++; if (time_set !== mkTime(23, 0, 59)) begin nFail++; $display("[TB] FAIL wrap_sec_dec: got %h expected %h", time_set, mkTime(23, 0, 59)); end
    press(1'b0, 1'b0, 1'b1);
    nChecks++; if (time_set !== mkTime(23, 0, 58)) begin nFail++; $display("[TB] FAIL sec_dec: got %h expected %h", time_set, mkTime(23, 0, 58)); end
    leaveToIdle(1);
    nChecks++; if (time_set !== mkTime(23, 0, 58) || time_ow !== 1'b0) begin nFail++; $display("[TB] FAIL wrap_after_commit: got %h/%b expected %h/0", time_set, time_ow, mkTime(23, 0, 58)); end
  endtask

  task automatic test_simultaneous();
    time_cur = mkTime(5, 10, 20);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    nChecks++; if (time_set !== mkTime(5, 10, 20)) begin nFail++; $display("[TB] FAIL simul_inc_dec: got %h expected %h", time_set, mkTime(5, 10, 20)); end
    press(1'b1, 1'b1, 1'b0);
    nChecks++; if (edit_field !== 2'd3 || time_set !== mkTime(5, 10, 20)) begin nFail++; $display("[TB] FAIL simul_mode_inc: got f=%0d %h expected 3 %h", edit_field, time_set, mkTime(5, 10, 20)); end
    leaveToIdle(1);
  endtask

  task automatic test_out_of_range();
    time_cur = mkTime(30, 61, 63);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(0, 61, 63)) begin nFail++; $display("[TB] FAIL oor_hr_inc: got %h expected %h", time_set, mkTime(0, 61, 63)); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    nChecks++; if (time_set !== mkTime(0, 59, 63)) begin nFail++; $display("[TB] FAIL oor_min_dec: got %h expected %h", time_set, mkTime(0, 59, 63)); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(0, 59, 0)) begin nFail++; $display("[TB] FAIL oor_sec_inc: got %h expected %h", time_set, mkTime(0, 59, 0)); end
    leaveToIdle(1);
  endtask

  task automatic test_held_through_reset();
    btn_inc = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    time_cur = mkTime(3, 4, 5);
    tick();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick(); tick();
    nChecks++; if (time_set !== mkTime(3, 4, 5) || edit_field !== 2'd1) begin nFail++; $display("[TB] FAIL held_no_inc: got %h f=%0d expected %h f=1", time_set, edit_field, mkTime(3, 4, 5)); end
    btn_inc = 1'b0;
    tick();
    press(1'b0, 1'b1, 1'b0);
    nChecks++; if (time_set !== mkTime(4, 4, 5)) begin nFail++; $display("[TB] FAIL held_repress_inc: got %h expected %h", time_set, mkTime(4, 4, 5)); end
    leaveToIdle(3);
  endtask

  task automatic test_timeout();
    logic sawOw;
    time_cur = mkTime(1, 2, 3);
    sawOw = 1'b0;
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      tick();
      if (time_ow === 1'b1) sawOw = 1'b1;
    end
    nChecks++; if (editing !== 1'b1 || edit_field !== 2'd1) begin nFail++; $display("[TB] FAIL timeout_early: got ed=%b f=%0d expected 1/1", editing, edit_field); end
    tick();
    if (time_ow === 1'b1) sawOw = 1'b1;
    nChecks++; if (editing !== 1'b0 || edit_field !== 2'd0) begin nFail++; $display("[TB] FAIL timeout_expire: got ed=%b f=%0d expected 0/0", editing, edit_field); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (time_ow === 1'b1) sawOw = 1'b1;
    end
    nChecks++; if (sawOw !== 1'b0) begin nFail++; $display("[TB] FAIL timeout_no_ow: got %b expected 0", sawOw); end
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      if (time_ow === 1'b1) sawOw = 1'b1;
    end
    nChecks++; if (editing !== 1'b1 || edit_field !== 2'd1) begin nFail++; $display("[TB] FAIL no_timeout: got ed=%b f=%0d expected 1/1", editing, edit_field); end
    nChecks++; if (sawOw !== 1'b0) begin nFail++; $display("[TB] FAIL no_timeout_ow: got %b expected 0", sawOw); end
    leaveToIdle(3);
`endif
  endtask

  task automatic test_reset_in_commit();
    time_cur = mkTime(9, 8, 7);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
    nChecks++; if (time_ow !== 1'b1) begin nFail++; $display("[TB] FAIL rstc_ow_before: got %b expected 1", time_ow); end
    rst = 1'b1; btn_mode = 1'b1;
    tick();
    rst = 1'b0; btn_mode = 1'b0;
    nChecks++; if (time_ow !== 1'b0 || editing !== 1'b0 || edit_field !== 2'd0 || time_set !== 17'd0) begin nFail++; $display("[TB] FAIL rstc_outputs: got ow=%b ed=%b f=%0d ts=%h expected 0/0/0/0", time_ow, editing, edit_field, time_set); end
    tick(); tick();
    nChecks++; if (time_ow !== 1'b0 || editing !== 1'b0) begin nFail++; $display("[TB] FAIL rstc_no_pulse: got ow=%b ed=%b expected 0/0", time_ow, editing); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_wrap();
    test_simultaneous();
    test_out_of_range();
    test_held_through_reset();
    test_timeout();
    test_reset_in_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
